// File: rtl/alu_op_issuer_if.sv
// Command / ALU / response bundle for alu_op_issuer.
//   cmd_*  : operation request (valid/ready), issuer is the target
//   alu_*  : registered operands/opcode out, combinational result/flags back
//   rsp_*  : captured result, flags and evaluated condition (valid/ready)
//   op_count : number of completed response handshakes
// slave  = issuer side, master = sequencer / environment side.
interface alu_op_issuer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_cond;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_of;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_pf;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_c;
  logic             rsp_of;
  logic             rsp_zf;
  logic             rsp_sf;
  logic             rsp_pf;
  logic             rsp_cond;

  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cond,
    input  alu_c, alu_of, alu_zf, alu_sf, alu_pf,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_c, rsp_of, rsp_zf, rsp_sf, rsp_pf, rsp_cond,
    output op_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cond,
    output alu_c, alu_of, alu_zf, alu_sf, alu_pf,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_c, rsp_of, rsp_zf, rsp_sf, rsp_pf, rsp_cond,
    input  op_count
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Initiator-side controller for the flag-producing ALU.
// Accepts a command in IDLE, drives registered operands/opcode to the ALU,
// waits SETTLE_CYCLES edges, captures result + flags, evaluates the
// selected branch condition and holds the response until it is accepted.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_op_issuer_if.slave (cmd_*, alu_*, rsp_*, op_count)
module alu_op_issuer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,   // 1..15
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_issuer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [2:0]       cond_q, cond_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             pf_q, pf_d;
  logic             rcond_q, rcond_d;
  logic [CNT_W-1:0] count_q, count_d;

  // cond[2:1] selects the flag (ZF, SF, OF, PF), cond[0] inverts it.
  function automatic logic cond_eval(input logic [2:0] cond,
                                     input logic of, input logic zf,
                                     input logic sf, input logic pf);
    logic f;
    case (cond[2:1])
      2'b00:   f = zf;
      2'b01:   f = sf;
      2'b10:   f = of;
      default: f = pf;
    endcase
    return f ^ cond[0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cond_d  = cond_q;
    c_d     = c_q;
    of_d    = of_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    pf_d    = pf_q;
    rcond_d = rcond_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          op_d    = bus.cmd_op;
          cond_d  = bus.cmd_cond;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          // Capture edge: the only point where ALU outputs are observed.
          c_d     = bus.alu_c;
          of_d    = bus.alu_of;
          zf_d    = bus.alu_zf;
          sf_d    = bus.alu_sf;
          pf_d    = bus.alu_pf;
          rcond_d = cond_eval(cond_q, bus.alu_of, bus.alu_zf,
                              bus.alu_sf, bus.alu_pf);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cond_q  <= '0;
      c_q     <= '0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      pf_q    <= 1'b0;
      rcond_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      c_q     <= c_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      pf_q    <= pf_d;
      rcond_q <= rcond_d;
      count_q <= count_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_c     = c_q;
  assign bus.rsp_of    = of_q;
  assign bus.rsp_zf    = zf_q;
  assign bus.rsp_sf    = sf_q;
  assign bus.rsp_pf    = pf_q;
  assign bus.rsp_cond  = rcond_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer. Two instances share clk/rst:
//   u_dut_a : SETTLE_CYCLES=1, CNT_W=16
//   u_dut_b : SETTLE_CYCLES=3, CNT_W=4
// The bench plays the ALU by driving alu_c/flags directly.
module tb_alu_op_issuer;

  logic clk;
  logic rst;

  int unsigned total;
  int unsigned bad;

  alu_op_issuer_if #(.WIDTH(8), .CNT_W(16)) bus_a ();
  alu_op_issuer_if #(.WIDTH(8), .CNT_W(4))  bus_b ();

  alu_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  alu_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_a_set(input logic [7:0] c, input logic of,
                           input logic zf, input logic sf, input logic pf);
    bus_a.alu_c  = c;
    bus_a.alu_of = of;
    bus_a.alu_zf = zf;
    bus_a.alu_sf = sf;
    bus_a.alu_pf = pf;
  endtask

  task automatic alu_b_set(input logic [7:0] c, input logic of,
                           input logic zf, input logic sf, input logic pf);
    bus_b.alu_c  = c;
    bus_b.alu_of = of;
    bus_b.alu_zf = zf;
    bus_b.alu_sf = sf;
    bus_b.alu_pf = pf;
  endtask

  // One complete op on instance B with rsp_ready held high; bounded wait.
  task automatic op_b(input logic [7:0] a);
    int unsigned n;
    bus_b.cmd_a     = a;
    bus_b.cmd_b     = 8'h01;
    bus_b.cmd_op    = 2'b01;
    bus_b.cmd_cond  = 3'b000;
    bus_b.rsp_ready = 1'b1;
    bus_b.cmd_valid = 1'b1;
    tick();
    bus_b.cmd_valid = 1'b0;
    n = 0;
    while (bus_b.rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("op_b_rsp_seen", 32'(bus_b.rsp_valid), 32'd1);
    tick();
  endtask

  logic [7:0] sweep_exp;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_a = '0; bus_a.cmd_b = '0;
    bus_a.cmd_op = '0; bus_a.cmd_cond = '0; bus_a.rsp_ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_a = '0; bus_b.cmd_b = '0;
    bus_b.cmd_op = '0; bus_b.cmd_cond = '0; bus_b.rsp_ready = 1'b0;
    alu_a_set(8'h00, 0, 0, 0, 0);
    alu_b_set(8'h00, 0, 0, 0, 0);

    // 1. reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst_alu_a",     32'(bus_a.alu_a), 32'h00);
    chk("rst_alu_b",     32'(bus_a.alu_b), 32'h00);
    chk("rst_alu_op",    32'(bus_a.alu_op), 32'h0);
    chk("rst_op_count",  32'(bus_a.op_count), 32'd0);
    chk("rst_b_ready",   32'(bus_b.cmd_ready), 32'd1);

    // 2. basic op, SETTLE_CYCLES=1
    bus_a.cmd_a = 8'h0F; bus_a.cmd_b = 8'hF0;
    bus_a.cmd_op = 2'b00; bus_a.cmd_cond = 3'b000;
    bus_a.rsp_ready = 1'b1;
    bus_a.cmd_valid = 1'b1;
    tick();                              // E0
    bus_a.cmd_valid = 1'b0;
    chk("basic_alu_a",     32'(bus_a.alu_a), 32'h0F);
    chk("basic_alu_b",     32'(bus_a.alu_b), 32'hF0);
    chk("basic_alu_op",    32'(bus_a.alu_op), 32'h0);
    chk("basic_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
    chk("basic_no_rsp",    32'(bus_a.rsp_valid), 32'd0);
    alu_a_set(8'hFF, 0, 0, 1, 1);
    tick();                              // E1
    chk("basic_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
    chk("basic_rsp_c",     32'(bus_a.rsp_c), 32'hFF);
    chk("basic_rsp_sf",    32'(bus_a.rsp_sf), 32'd1);
    chk("basic_rsp_pf",    32'(bus_a.rsp_pf), 32'd1);
    chk("basic_rsp_zf",    32'(bus_a.rsp_zf), 32'd0);
    chk("basic_rsp_of",    32'(bus_a.rsp_of), 32'd0);
    chk("basic_rsp_cond",  32'(bus_a.rsp_cond), 32'd0);
    tick();                              // handshake
    chk("basic_rsp_drop",  32'(bus_a.rsp_valid), 32'd0);
    chk("basic_op_count",  32'(bus_a.op_count), 32'd1);
    chk("basic_idle",      32'(bus_a.cmd_ready), 32'd1);
    chk("basic_rsp_keep",  32'(bus_a.rsp_c), 32'hFF);

    // 3. backpressure with ALU output churning
    bus_a.cmd_a = 8'h03; bus_a.cmd_b = 8'h04;
    bus_a.cmd_op = 2'b01; bus_a.cmd_cond = 3'b001;
    bus_a.rsp_ready = 1'b0;
    bus_a.cmd_valid = 1'b1;
    tick();                              // accept
    bus_a.cmd_a = 8'hAA; bus_a.cmd_b = 8'h55;
    bus_a.cmd_op = 2'b10; bus_a.cmd_cond = 3'b000;
    alu_a_set(8'h07, 0, 0, 0, 0);
    tick();                              // capture
    chk("bp_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
    chk("bp_rsp_c",     32'(bus_a.rsp_c), 32'h07);
    chk("bp_rsp_cond",  32'(bus_a.rsp_cond), 32'd1);
    for (int i = 0; i < 5; i++) begin
      alu_a_set(8'(8'h20 + 8'(i) * 8'h11), 1, 1, 1, 1);
      tick();
      chk("bp_hold_c",     32'(bus_a.rsp_c), 32'h07);
      chk("bp_hold_zf",    32'(bus_a.rsp_zf), 32'd0);
      chk("bp_cmd_ready",  32'(bus_a.cmd_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus_a.rsp_valid), 32'd1);
      chk("bp_alu_a_hold", 32'(bus_a.alu_a), 32'h03);
    end
    bus_a.rsp_ready = 1'b1;
    tick();                              // handshake
    chk("bp_hs_valid",   32'(bus_a.rsp_valid), 32'd0);
    chk("bp_hs_ready",   32'(bus_a.cmd_ready), 32'd1);
    chk("bp_hs_alu_a",   32'(bus_a.alu_a), 32'h03);
    chk("bp_hs_count",   32'(bus_a.op_count), 32'd2);
    tick();                              // second command accepted here
    bus_a.cmd_valid = 1'b0;
    chk("bp_acc2_alu_a", 32'(bus_a.alu_a), 32'hAA);
    chk("bp_acc2_alu_op", 32'(bus_a.alu_op), 32'h2);
    tick();
    chk("bp_rsp2_valid", 32'(bus_a.rsp_valid), 32'd1);
    tick();
    chk("bp_rsp2_count", 32'(bus_a.op_count), 32'd3);

    // 5. condition sweep, flags OF=1 ZF=0 SF=1 PF=0
    sweep_exp = 8'b1001_0110;            // bit k = expected rsp_cond for cond k
    alu_a_set(8'h80, 1, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      bus_a.cmd_cond  = 3'(k);
      bus_a.rsp_ready = 1'b1;
      bus_a.cmd_valid = 1'b1;
      tick();
      bus_a.cmd_valid = 1'b0;
      tick();
      chk("sweep_valid", 32'(bus_a.rsp_valid), 32'd1);
      chk($sformatf("sweep_cond%0d", k), 32'(bus_a.rsp_cond),
          32'(sweep_exp[k]));
      tick();
    end
    chk("sweep_count", 32'(bus_a.op_count), 32'd11);

    // 4. settle timing, SETTLE_CYCLES=3
    bus_b.cmd_a = 8'h10; bus_b.cmd_b = 8'h10;
    bus_b.cmd_op = 2'b01; bus_b.cmd_cond = 3'b000;
    bus_b.rsp_ready = 1'b0;
    alu_b_set(8'h55, 1, 0, 1, 1);
    bus_b.cmd_valid = 1'b1;
    tick();                              // E0
    bus_b.cmd_valid = 1'b0;
    chk("settle_alu_a", 32'(bus_b.alu_a), 32'h10);
    tick();                              // E1
    chk("settle_e1", 32'(bus_b.rsp_valid), 32'd0);
    alu_b_set(8'hAA, 0, 0, 1, 0);
    tick();                              // E2
    chk("settle_e2", 32'(bus_b.rsp_valid), 32'd0);
    alu_b_set(8'h00, 0, 1, 0, 0);
    tick();                              // E3
    chk("settle_e3_valid", 32'(bus_b.rsp_valid), 32'd1);
    chk("settle_rsp_c",    32'(bus_b.rsp_c), 32'h00);
    chk("settle_rsp_zf",   32'(bus_b.rsp_zf), 32'd1);
    chk("settle_rsp_sf",   32'(bus_b.rsp_sf), 32'd0);
    chk("settle_rsp_cond", 32'(bus_b.rsp_cond), 32'd1);
    alu_b_set(8'h3C, 1, 0, 1, 1);
    bus_b.rsp_ready = 1'b1;
    tick();
    chk("settle_count", 32'(bus_b.op_count), 32'd1);
    chk("settle_keep_c", 32'(bus_b.rsp_c), 32'h00);

    // 6a. reset during SETTLE discards the command
    bus_b.rsp_ready = 1'b1;
    bus_b.cmd_valid = 1'b1;
    tick();
    bus_b.cmd_valid = 1'b0;
    tick();                              // inside SETTLE
    chk("midrst_busy", 32'(bus_b.cmd_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(bus_b.cmd_ready), 32'd1);
    chk("midrst_count", 32'(bus_b.op_count), 32'd0);
    chk("midrst_alu_a", 32'(bus_b.alu_a), 32'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus_b.rsp_valid), 32'd0);
    end

    // 6b. 4-bit counter wrap
    for (int i = 0; i < 15; i++) op_b(8'(i));
    chk("wrap_15", 32'(bus_b.op_count), 32'd15);
    op_b(8'h0F);
    chk("wrap_16", 32'(bus_b.op_count), 32'd0);
    op_b(8'h10);
    chk("wrap_17", 32'(bus_b.op_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
